// File: rtl/keypad_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl_pkg
//   Shared definitions for the keypad scanner and the display blocks that
//   consume its key codes.
//   - kp_state_t : debounce FSM state encoding
//   - COL_RESET  : column drive value after reset (column 0 driven low)
//   - KEY_SEG    : key code (0-F) to 7-segment pattern, bit order gfedcba,
//                  active-high segments
//   - key_to_seg : lookup helper around KEY_SEG
// -----------------------------------------------------------------------------
package keypad_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } kp_state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    localparam logic [6:0] KEY_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    function automatic logic [6:0] key_to_seg(input logic [3:0] code);
        return KEY_SEG[code];
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync.sv
// -----------------------------------------------------------------------------
// key_sync2
//   4-bit two-flop synchronizer for the asynchronous keypad row inputs.
//   Resets to all ones (no key pressed) so nothing spurious is seen after
//   reset.
//   clk : system clock
//   rst : synchronous reset, active-low
//   d   : asynchronous row inputs
//   q   : synchronized rows
// -----------------------------------------------------------------------------
module key_sync2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//   Scans a 4x4 matrix keypad by driving one column low per slot and sampling
//   the rows. Each frame is four slots. Presses and releases are debounced over
//   DEBOUNCE_FRAMES identical frames. Each accepted press gives one event.
//   Parameters:
//     SCAN_DIV        : a slot lasts SCAN_DIV+1 clk cycles (>= 3)
//     DEBOUNCE_FRAMES : identical frames needed to accept press/release (>= 1)
//   Ports:
//     clk       : system clock
//     rst       : synchronous reset, active-low
//     row[3:0]  : keypad rows, pulled up, 0 = pressed on driven column (async)
//     col[3:0]  : column drive, exactly one bit low
//     key_code  : code of accepted key, row_idx*4 + col_idx, held
//     key_valid : one-cycle pulse when a press is accepted
//     key_down  : high while the accepted key is held
// -----------------------------------------------------------------------------
module keypad_scan_ctrl
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV        = 99999,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int CNT_W  = $clog2(SCAN_DIV + 1);
    localparam int DCNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SCAN_DIV);
    localparam logic [DCNT_W-1:0] DF_N      = DCNT_W'(DEBOUNCE_FRAMES);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

    logic [3:0]        row_s;
    logic [CNT_W-1:0]  slot_cnt;
    logic [1:0]        col_idx;
    logic [1:0]        acc_cnt;     // keys seen so far this frame, saturates at 2
    logic [3:0]        acc_code;    // last key code seen this frame
    kp_state_t         state;
    logic [3:0]        cand;
    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dcnt_inc;

    logic       slot_tick;
    logic       frame_end;
    logic [1:0] tot_cnt;
    logic [3:0] tot_code;
    logic       frame_none;
    logic       frame_one;

    key_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (row_s)
    );

    assign slot_tick = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_tick && (col_idx == 2'd3);
    assign dcnt_inc  = dcnt + DCNT_ONE;

    // Running frame totals including the slot being sampled now. At frame end
    // these describe the whole frame, so the FSM reads them directly.
    always_comb begin
        tot_cnt  = acc_cnt;
        tot_code = acc_code;
        for (int r = 0; r < 4; r++) begin
            if (!row_s[r]) begin
                tot_code = {2'(r), col_idx};
                if (tot_cnt != 2'd2) begin
                    tot_cnt = tot_cnt + 2'd1;
                end
            end
        end
    end

    assign frame_none = (tot_cnt == 2'd0);
    assign frame_one  = (tot_cnt == 2'd1);

    // Slot timing, column rotation and per-frame accumulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            col      <= COL_RESET;
            acc_cnt  <= 2'd0;
            acc_code <= 4'd0;
        end else if (slot_tick) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            col      <= {col[2:0], col[3]};
            if (col_idx == 2'd3) begin
                acc_cnt  <= 2'd0;
                acc_code <= 4'd0;
            end else begin
                acc_cnt  <= tot_cnt;
                acc_code <= tot_code;
            end
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Debounce FSM with registered outputs; only advances at frame end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RELEASED;
            cand      <= 4'd0;
            dcnt      <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    RELEASED: begin
                        if (frame_one) begin
                            cand <= tot_code;
                            if (DEBOUNCE_FRAMES == 1) begin
                                key_code  <= tot_code;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                state     <= PRESSED;
                                dcnt      <= '0;
                            end else begin
                                state <= PRESS_CHK;
                                dcnt  <= DCNT_ONE;
                            end
                        end
                    end
                    PRESS_CHK: begin
                        if (frame_one && (tot_code == cand)) begin
                            if (dcnt_inc == DF_N) begin
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                state     <= PRESSED;
                                dcnt      <= '0;
                            end else begin
                                dcnt <= dcnt_inc;
                            end
                        end else if (frame_one) begin
                            // A different single key restarts the count.
                            cand <= tot_code;
                            dcnt <= DCNT_ONE;
                        end else begin
                            state <= RELEASED;
                            dcnt  <= '0;
                        end
                    end
                    PRESSED: begin
                        // Extra or rolled keys are ignored until all keys lift.
                        if (frame_none) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                state    <= RELEASED;
                                key_down <= 1'b0;
                                dcnt     <= '0;
                            end else begin
                                state <= RELEASE_CHK;
                                dcnt  <= DCNT_ONE;
                            end
                        end
                    end
                    RELEASE_CHK: begin
                        if (frame_none) begin
                            if (dcnt_inc == DF_N) begin
                                state    <= RELEASED;
                                key_down <= 1'b0;
                                dcnt     <= '0;
                            end else begin
                                dcnt <= dcnt_inc;
                            end
                        end else begin
                            state <= PRESSED;
                            dcnt  <= '0;
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        dcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//   Bench for keypad_scan_ctrl with SCAN_DIV=3 (16-cycle frame) and
//   DEBOUNCE_FRAMES=3. A keypad model pulls a row low whenever a held key sits
//   on the column currently driven low. Key patterns change only on frame
//   boundaries; outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

    localparam int FRAME_CYC = 16;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] keys;   // bit r*4+c set = key at row r, column c held

    int n_checks;
    int n_fail;
    int pulses;

    typedef struct {
        string       name;
        logic [15:0] keys;
        int          nfr;
        int          pulses;
        logic        kv;
        logic        down;
        logic [3:0]  code;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    keypad_scan_ctrl #(
        .SCAN_DIV        (3),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- keypad model ----------------
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[r*4 + c]) row[r] = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs n whole frames from a falling edge; counts key_valid pulses and
    // returns at the falling edge just after the last frame-end edge.
    task automatic run_frames(input int n);
        pulses = 0;
        for (int i = 0; i < n * FRAME_CYC; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid) pulses++;
        end
    endtask

    task automatic check_state(input string name, input int exp_pulses,
                               input logic kv, input logic down, input logic [3:0] code);
        check({name, ".pulses"},    32'(pulses),    32'(exp_pulses));
        check({name, ".key_valid"}, 32'(key_valid), 32'(kv));
        check({name, ".key_down"},  32'(key_down),  32'(down));
        check({name, ".key_code"},  32'(key_code),  32'(code));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] exp_col;
        logic [3:0] col_seq [4];

        n_checks = 0;
        n_fail   = 0;
        pulses   = 0;
        keys     = 16'h0000;
        rst      = 1'b0;

        col_seq[0] = 4'b1110;
        col_seq[1] = 4'b1101;
        col_seq[2] = 4'b1011;
        col_seq[3] = 4'b0111;

        // clean press of key 6 (row1,col2), 6 frames, then release
        vecs[0]  = '{"press6_a",   16'h0040, 2, 0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{"press6_acc", 16'h0040, 1, 1, 1'b1, 1'b1, 4'd6};
        vecs[2]  = '{"press6_hold",16'h0040, 3, 0, 1'b0, 1'b1, 4'd6};
        vecs[3]  = '{"rel6_a",     16'h0000, 2, 0, 1'b0, 1'b1, 4'd6};
        vecs[4]  = '{"rel6_acc",   16'h0000, 1, 0, 1'b0, 1'b0, 4'd6};
        // bounce: key 6 in alternate frames for 8 frames
        vecs[5]  = '{"bounce1",    16'h0040, 1, 0, 1'b0, 1'b0, 4'd6};
        vecs[6]  = '{"bounce2",    16'h0000, 1, 0, 1'b0, 1'b0, 4'd6};
        vecs[7]  = '{"bounce3",    16'h0040, 1, 0, 1'b0, 1'b0, 4'd6};
        vecs[8]  = '{"bounce4",    16'h0000, 1, 0, 1'b0, 1'b0, 4'd6};
        vecs[9]  = '{"bounce5",    16'h0040, 1, 0, 1'b0, 1'b0, 4'd6};
        vecs[10] = '{"bounce6",    16'h0000, 1, 0, 1'b0, 1'b0, 4'd6};
        vecs[11] = '{"bounce7",    16'h0040, 1, 0, 1'b0, 1'b0, 4'd6};
        vecs[12] = '{"bounce8",    16'h0000, 1, 0, 1'b0, 1'b0, 4'd6};
        vecs[13] = '{"steady6",    16'h0040, 3, 1, 1'b1, 1'b1, 4'd6};
        vecs[14] = '{"steady6_rel",16'h0000, 3, 0, 1'b0, 1'b0, 4'd6};
        // multi-key 0+15, then only key 0
        vecs[15] = '{"multi",      16'h8001, 5, 0, 1'b0, 1'b0, 4'd6};
        vecs[16] = '{"multi_to0",  16'h0001, 3, 1, 1'b1, 1'b1, 4'd0};
        vecs[17] = '{"rel0",       16'h0000, 3, 0, 1'b0, 1'b0, 4'd0};
        // release glitch on key 9 (row2,col1)
        vecs[18] = '{"press9",     16'h0200, 3, 1, 1'b1, 1'b1, 4'd9};
        vecs[19] = '{"glitch9",    16'h0000, 1, 0, 1'b0, 1'b1, 4'd9};
        vecs[20] = '{"repress9",   16'h0200, 2, 0, 1'b0, 1'b1, 4'd9};
        vecs[21] = '{"rel9_a",     16'h0000, 2, 0, 1'b0, 1'b1, 4'd9};
        vecs[22] = '{"rel9_acc",   16'h0000, 1, 0, 1'b0, 1'b0, 4'd9};
        // candidate restart: 6 for 2 frames, then 5 needs a fresh 3 frames
        vecs[23] = '{"cand6",      16'h0040, 2, 0, 1'b0, 1'b0, 4'd9};
        vecs[24] = '{"cand5_a",    16'h0020, 2, 0, 1'b0, 1'b0, 4'd9};
        vecs[25] = '{"cand5_acc",  16'h0020, 1, 1, 1'b1, 1'b1, 4'd5};
        vecs[26] = '{"rel5",       16'h0000, 3, 0, 1'b0, 1'b0, 4'd5};
        vecs[27] = '{"idle",       16'h0000, 1, 0, 1'b0, 1'b0, 4'd5};

        // ---- scenario 1: reset, no keys ----
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("reset.col", 32'(col), 32'(4'b1110));
        end
        check("reset.key_valid", 32'(key_valid), 32'd0);
        check("reset.key_down",  32'(key_down),  32'd0);
        check("reset.key_code",  32'(key_code),  32'd0);
        rst = 1'b1;

        // first frame after reset: column rotates every 4 cycles
        pulses = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid) pulses++;
            exp_col = col_seq[((i + 1) / 4) % 4];
            check($sformatf("scan.col[%0d]", i), 32'(col), 32'(exp_col));
        end
        check("scan.pulses", 32'(pulses), 32'd0);
        run_frames(1);
        check_state("idle0", 0, 1'b0, 1'b0, 4'd0);

        // ---- scenarios 2-5 and candidate restart: table ----
        for (int v = 0; v < NV; v++) begin
            keys = vecs[v].keys;
            run_frames(vecs[v].nfr);
            check_state(vecs[v].name, vecs[v].pulses, vecs[v].kv, vecs[v].down, vecs[v].code);
        end

        // ---- scenario 6: reset mid-press on key 3 (row0,col3) ----
        keys = 16'h0008;
        run_frames(3);
        check_state("press3", 1, 1'b1, 1'b1, 4'd3);
        run_frames(1);
        check_state("hold3", 0, 1'b0, 1'b1, 4'd3);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst3.key_down",  32'(key_down),  32'd0);
        check("rst3.key_code",  32'(key_code),  32'd0);
        check("rst3.key_valid", 32'(key_valid), 32'd0);
        check("rst3.col",       32'(col),       32'(4'b1110));
        run_frames(2);
        check_state("rst3_deb", 0, 1'b0, 1'b0, 4'd0);
        run_frames(1);
        check_state("rst3_acc", 1, 1'b1, 1'b1, 4'd3);
        keys = 16'h0000;
        run_frames(3);
        check_state("rst3_rel", 0, 1'b0, 1'b0, 4'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
